// File: rtl/hamming_encoder_tx.sv
// rtl/hamming_encoder_tx.sv - FIFO-buffered (8,4) SECDED encoder with registered output
// Define HAMMING_TX_ERR_INJECT_EN to XOR inject_mask into each codeword at load time.
module hamming_encoder_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [7:0]               inject_mask,
    output logic [CNT_W-1:0]         tx_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [7:0]    mask_eff;
    logic          push;
    logic          load;

    // Codeword layout: {P4, D4, D3, D2, P3, D1, P2, P1}; P4 gives even parity over all 8 bits.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return {^c, c};
    endfunction

`ifdef HAMMING_TX_ERR_INJECT_EN
    assign mask_eff = inject_mask;
`else
    logic unused_mask;
    assign unused_mask = ^inject_mask;
    assign mask_eff    = 8'h00;
`endif

    assign in_ready   = (level != FULL_LVL);
    assign fifo_level = level;
    assign push       = in_valid & in_ready;
    assign load       = (level != '0) & (~out_valid | out_ready);

    // Storage needs no reset: the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_code  <= 8'h00;
            out_valid <= 1'b0;
            tx_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // out_code only changes on a load, so it stays bit-stable while stalled.
            if (load) begin
                out_code  <= encode(mem[rd_ptr]) ^ mask_eff;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid & out_ready) begin
                tx_count <= tx_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// tb/tb_hamming_encoder_tx.sv - self-checking bench for hamming_encoder_tx (DEPTH=4, CNT_W=4)
module tb_hamming_encoder_tx;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

`ifdef HAMMING_TX_ERR_INJECT_EN
    localparam logic [7:0] EXP_M04 = 8'h51;
    localparam logic [7:0] EXP_M14 = 8'h41;
`else
    localparam logic [7:0] EXP_M04 = 8'h55;
    localparam logic [7:0] EXP_M14 = 8'h55;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       in_data = 4'h0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       out_code;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       inject_mask = 8'h00;
    logic [CNT_W-1:0] tx_count;
    logic [2:0]       fifo_level;

    hamming_encoder_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
        .inject_mask(inject_mask), .tx_count(tx_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [7:0] code;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] sb [$];
    int         checks = 0;
    int         errors = 0;
    int         exp_cnt = 0;

    function automatic logic [7:0] ref_code(input logic [3:0] d);
        logic d1, d2, d3, d4, p1, p2, p3;
        logic [6:0] low;
        d1 = d[0]; d2 = d[1]; d3 = d[2]; d4 = d[3];
        p1 = d1 ^ d2 ^ d4;
        p2 = d1 ^ d3 ^ d4;
        p3 = d2 ^ d3 ^ d4;
        low = {d4, d3, d2, p3, d1, p2, p1};
        return {^low, low};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, score the handshakes that will fire, sample #1 after posedge.
    task automatic step(input logic v, input logic [3:0] d, input logic [7:0] exp,
                        input logic r, input logic [7:0] m);
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r; inject_mask = m;
        if (v && in_ready) sb.push_back(exp);
        if (out_valid && r) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {24'h0, out_code}, 32'hFFFF_FFFF);
            end else begin
                check("sb_code", {24'h0, out_code}, {24'h0, sb.pop_front()});
            end
            exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (sb.size() != 0 || out_valid); k++) step(1'b0, 4'h0, 8'h00, 1'b1, 8'h00);
        check("drain_empty", sb.size(), 0);
        check("drain_tx_count", {28'h0, tx_count}, exp_cnt % 16);
    endtask

    task automatic do_reset(input logic v, input logic r);
        @(negedge clk);
        rst = 1'b1; in_valid = v; in_data = 4'h5; out_ready = r; inject_mask = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        logic       stable, lvl_ok, val_ok;
        int         gaps;

        vecs[0] = '{4'h0, 8'h00};
        vecs[1] = '{4'h1, 8'h87};
        vecs[2] = '{4'hB, 8'h55};
        vecs[3] = '{4'hF, 8'hFF};

        do_reset(1'b0, 1'b0);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_out_code", {24'h0, out_code}, 0);
        check("rst_tx_count", {28'h0, tx_count}, 0);
        check("rst_fifo_level", {29'h0, fifo_level}, 0);
        check("rst_in_ready", {31'h0, in_ready}, 1);

        // Encoding vectors with latency check on the first two pushes.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vecs[i].data, vecs[i].code, 1'b1, 8'h00);
            if (i == 0) begin
                check("lat_pre_valid", {31'h0, out_valid}, 0);
                check("lat_pre_level", {29'h0, fifo_level}, 1);
            end
            if (i == 1) begin
                check("lat_valid", {31'h0, out_valid}, 1);
                check("lat_code", {24'h0, out_code}, 8'h00);
            end
        end
        drain();
        check("t1_tx_count", {28'h0, tx_count}, 4);

        // Backpressure: sixth word must be refused, output held bit-stable.
        do_reset(1'b0, 1'b0);
        step(1'b1, 4'h3, ref_code(4'h3), 1'b0, 8'h00);
        step(1'b1, 4'h5, ref_code(4'h5), 1'b0, 8'h00);
        held = out_code;
        stable = 1'b1;
        step(1'b1, 4'h6, ref_code(4'h6), 1'b0, 8'h00); if (out_code !== held) stable = 1'b0;
        step(1'b1, 4'h9, ref_code(4'h9), 1'b0, 8'h00); if (out_code !== held) stable = 1'b0;
        step(1'b1, 4'hC, ref_code(4'hC), 1'b0, 8'h00); if (out_code !== held) stable = 1'b0;
        step(1'b1, 4'h7, ref_code(4'h7), 1'b0, 8'h00); if (out_code !== held) stable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
            if (out_code !== held) stable = 1'b0;
        end
        check("bp_first_code", {24'h0, out_code}, {24'h0, ref_code(4'h3)});
        check("bp_hold_stable", {31'h0, stable}, 1);
        check("bp_fifo_full", {29'h0, fifo_level}, 4);
        check("bp_in_ready", {31'h0, in_ready}, 0);
        check("bp_sb_words", sb.size(), 5);
        gaps = 0;
        for (int k = 0; k < 5; k++) begin
            if (!out_valid) gaps++;
            step(1'b0, 4'h0, 8'h00, 1'b1, 8'h00);
        end
        check("bp_release_gaps", gaps, 0);
        check("bp_release_done", {31'h0, out_valid}, 0);
        check("bp_release_sb", sb.size(), 0);

        // Steady push+pop every cycle for 20 cycles.
        do_reset(1'b0, 1'b0);
        step(1'b1, 4'h2, ref_code(4'h2), 1'b1, 8'h00);
        step(1'b1, 4'hA, ref_code(4'hA), 1'b1, 8'h00);
        lvl_ok = 1'b1;
        val_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] w;
            w = 4'($urandom_range(0, 15));
            step(1'b1, w, ref_code(w), 1'b1, 8'h00);
            if (fifo_level !== 3'd1) lvl_ok = 1'b0;
            if (out_valid !== 1'b1) val_ok = 1'b0;
        end
        check("pp_level_const", {31'h0, lvl_ok}, 1);
        check("pp_no_gaps", {31'h0, val_ok}, 1);
        check("pp_tx_count", {28'h0, tx_count}, 20 % 16);
        drain();

        // Reset in the middle of a stalled transfer; reset beats concurrent push/pop.
        do_reset(1'b0, 1'b0);
        step(1'b1, 4'h4, ref_code(4'h4), 1'b1, 8'h00);
        step(1'b1, 4'h8, ref_code(4'h8), 1'b1, 8'h00);
        drain();
        for (int k = 0; k < 4; k++) step(1'b1, 4'(k + 3), ref_code(4'(k + 3)), 1'b0, 8'h00);
        check("mid_pre_level", {29'h0, fifo_level}, 3);
        check("mid_pre_valid", {31'h0, out_valid}, 1);
        do_reset(1'b1, 1'b1);
        check("mid_rst_valid", {31'h0, out_valid}, 0);
        check("mid_rst_level", {29'h0, fifo_level}, 0);
        check("mid_rst_tx", {28'h0, tx_count}, 0);
        check("mid_rst_code", {24'h0, out_code}, 0);
        step(1'b1, 4'h1, 8'h87, 1'b0, 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
        check("mid_after_code", {24'h0, out_code}, 8'h87);
        drain();

        // Counter wrap with a 4-bit counter.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 17; k++) step(1'b1, 4'(k), ref_code(4'(k)), 1'b1, 8'h00);
        drain();
        check("wrap_tx_count", {28'h0, tx_count}, 1);

        // Error injection: mask sampled only in the load cycle.
        do_reset(1'b0, 1'b0);
        step(1'b1, 4'hB, EXP_M04, 1'b0, 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b0, 8'h04);
        check("inj_m04_code", {24'h0, out_code}, {24'h0, EXP_M04});
        step(1'b1, 4'hB, EXP_M14, 1'b0, 8'hFF);
        check("inj_hold_code", {24'h0, out_code}, {24'h0, EXP_M04});
        step(1'b0, 4'h0, 8'h00, 1'b1, 8'h14);
        check("inj_m14_code", {24'h0, out_code}, {24'h0, EXP_M14});
        step(1'b1, 4'hB, 8'h55, 1'b1, 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b1, 8'h00);
        check("inj_clean_code", {24'h0, out_code}, 8'h55);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
